// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for a single shared 32-bit ALU.
// Each port owns a registered response slot with valid/ready backpressure.

module alu_share_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        ready,
  input  logic [31:0] d_result,
  input  logic        d_zero,
  input  logic        d_lt,
  input  logic        d_illegal,
  output logic        valid,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        illegal
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      lt      <= 1'b0;
      illegal <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      result  <= d_result;
      zero    <= d_zero;
      lt      <= d_lt;
      illegal <= d_illegal;
    end else if (ready) begin
      // consumed with no refill: drop valid, keep the data registers
      valid <= 1'b0;
    end
  end
endmodule

module alu_share_arb #(
  parameter int FIRST_PRIO = 0,
  parameter int CHECK_OPS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0][3:0]  req_ctrl,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [1:0][31:0] rsp_result,
  output logic [1:0]       rsp_zero,
  output logic [1:0]       rsp_lt,
  output logic [1:0]       rsp_illegal
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        illegal;
  } alu_rsp_t;

  logic [1:0] elig, grant;
  logic       prio;
  alu_req_t   held_q, alu_in;
  alu_rsp_t   alu_out;

  // a full slot may still be refilled in the cycle it drains
  assign elig      = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = grant;

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (elig == 2'b11) grant[prio] = 1'b1;
      else               grant = elig;
    end
  end

  always_comb begin
    alu_in = held_q;
    if (grant[0])      alu_in = '{a: req_a[0], b: req_b[0], ctrl: req_ctrl[0]};
    else if (grant[1]) alu_in = '{a: req_a[1], b: req_b[1], ctrl: req_ctrl[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio   <= 1'(FIRST_PRIO);
      held_q <= '0;
    end else begin
      held_q <= alu_in;
      if (|grant) prio <= grant[0];
    end
  end

  // zero/lt always come from the adder, whatever the selected result
  logic [31:0] bb, sum;
  logic        ovf, add_lt;
  logic [4:0]  sh;

  always_comb begin
    bb      = alu_in.ctrl[0] ? ~alu_in.b : alu_in.b;
    sum     = alu_in.a + bb + {31'b0, alu_in.ctrl[0]};
    ovf     = (alu_in.a[31] == bb[31]) && (sum[31] != alu_in.a[31]);
    add_lt  = sum[31] ^ ovf;
    sh      = alu_in.b[4:0];
    alu_out = '{result: '0, zero: (sum == '0), lt: add_lt, illegal: 1'b0};
    case (alu_in.ctrl)
      4'b0000, 4'b0001: alu_out.result = sum;
      4'b0010: alu_out.result = alu_in.a & alu_in.b;
      4'b0011: alu_out.result = alu_in.a | alu_in.b;
      4'b0100: alu_out.result = alu_in.a ^ alu_in.b;
      4'b0101: alu_out.result = {31'b0, add_lt};
      4'b0110: alu_out.result = alu_in.a << sh;
      4'b1000: alu_out.result = alu_in.a >> sh;
      4'b1110: alu_out.result = 32'($signed(alu_in.a) >>> sh);
      default: alu_out.illegal = (CHECK_OPS != 0);
    endcase
    if (alu_out.illegal) begin
      alu_out.result = '0;
      alu_out.zero   = 1'b1;
      alu_out.lt     = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
    alu_share_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (grant[gi]),
      .ready     (rsp_ready[gi]),
      .d_result  (alu_out.result),
      .d_zero    (alu_out.zero),
      .d_lt      (alu_out.lt),
      .d_illegal (alu_out.illegal),
      .valid     (rsp_valid[gi]),
      .result    (rsp_result[gi]),
      .zero      (rsp_zero[gi]),
      .lt        (rsp_lt[gi]),
      .illegal   (rsp_illegal[gi])
    );
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized bench for alu_share_arb against a transaction-level model,
// preceded by directed cases with hand-computed expectations.

module tb_alu_share_arb;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b, rsp_result;
  logic [1:0][3:0]  req_ctrl;
  logic [1:0]       rsp_zero, rsp_lt, rsp_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.FIRST_PRIO(0), .CHECK_OPS(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_lt(rsp_lt), .rsp_illegal(rsp_illegal)
  );

  // model state: what each response slot holds and who has priority
  int          m_prio;
  int          m_last_g;
  logic        m_vld [2];
  logic [31:0] m_res [2];
  logic        m_zero[2], m_lt[2], m_ill[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         output logic [31:0] r, output logic z, output logic l, output logic il);
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = c[0] ? sa - sb : sa + sb;
    il = 1'b0;
    r  = '0;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd14: r = $signed(a) >>> b[4:0];
      default: il = 1'b1;
    endcase
    z = (s[31:0] == 32'd0);
    l = (s < 0);
    if (il) begin r = '0; z = 1'b1; l = 1'b0; end
  endtask

  function automatic int exp_grant();
    bit e0, e1;
    if (reset) return -1;
    e0 = req_valid[0] && (!m_vld[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_vld[1] || rsp_ready[1]);
    if (e0 && e1) return m_prio;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_prio   = 0;
    m_last_g = -1;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_res[i] = '0; m_zero[i] = 0; m_lt[i] = 0; m_ill[i] = 0;
    end
  endtask

  // compare at the falling edge, then advance the model to the next rising edge
  task automatic cycle();
    int g;
    @(negedge clk);
    g = exp_grant();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("p%0d_req_ready", i), 32'(req_ready[i]), 32'(g == i));
      chk($sformatf("p%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'(m_vld[i]));
      chk($sformatf("p%0d_result", i), rsp_result[i], m_res[i]);
      chk($sformatf("p%0d_zero", i), 32'(rsp_zero[i]), 32'(m_zero[i]));
      chk($sformatf("p%0d_lt", i), 32'(rsp_lt[i]), 32'(m_lt[i]));
      chk($sformatf("p%0d_illegal", i), 32'(rsp_illegal[i]), 32'(m_ill[i]));
    end
    if (reset) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          ref_alu(req_a[i], req_b[i], req_ctrl[i], m_res[i], m_zero[i], m_lt[i], m_ill[i]);
          m_vld[i] = 1;
        end else if (rsp_ready[i]) m_vld[i] = 0;
      end
      if (g >= 0) m_prio = 1 - g;
      m_last_g = g;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] gseq [4];
    reset = 1; req_valid = '0; rsp_ready = 2'b11;
    req_a = '0; req_b = '0; req_ctrl = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_result0", rsp_result[0], 32'h0);

    // single add on port 0
    req_valid = 2'b01; req_a[0] = 5; req_b[0] = 7; req_ctrl[0] = 4'b0000;
    #1 chk("add_req_ready", 32'(req_ready), 32'h1);
    cycle();
    req_valid = 2'b00;
    chk("add_valid", 32'(rsp_valid[0]), 32'h1);
    chk("add_result", rsp_result[0], 32'd12);
    chk("add_flags", {29'b0, rsp_zero[0], rsp_lt[0], rsp_illegal[0]}, 32'h0);

    // sub / slt on port 1
    req_valid = 2'b10; req_a[1] = 3; req_b[1] = 3; req_ctrl[1] = 4'b0001;
    cycle();
    chk("sub_result", rsp_result[1], 32'h0);
    chk("sub_zero", 32'(rsp_zero[1]), 32'h1);
    req_a[1] = 32'hFFFF_FFFF; req_b[1] = 1; req_ctrl[1] = 4'b0101;
    cycle();
    chk("slt_result", rsp_result[1], 32'h1);
    chk("slt_lt", 32'(rsp_lt[1]), 32'h1);
    req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'hFFFF_FFFF;
    cycle();
    req_valid = 2'b00;
    chk("slt_ovf_result", rsp_result[1], 32'h0);
    chk("slt_ovf_lt", 32'(rsp_lt[1]), 32'h0);

    // contention: both ports valid, grants must alternate starting at port 0
    req_valid = 2'b11;
    req_a[0] = 1; req_b[0] = 4; req_ctrl[0] = 4'b0110;
    req_a[1] = 32'h8000_0000; req_b[1] = 31; req_ctrl[1] = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      #1 gseq[k] = req_ready;
      cycle();
      chk($sformatf("cont_valid%0d", k), 32'(rsp_valid), 32'(gseq[k]));
    end
    req_valid = 2'b00;
    chk("cont_g0", 32'(gseq[0]), 32'h1);
    chk("cont_g1", 32'(gseq[1]), 32'h2);
    chk("cont_g2", 32'(gseq[2]), 32'h1);
    chk("cont_g3", 32'(gseq[3]), 32'h2);
    chk("cont_sll", rsp_result[0], 32'd16);
    chk("cont_sra", rsp_result[1], 32'hFFFF_FFFF);
    cycle();

    // backpressure on port 0, then same-cycle drain and refill
    req_valid = 2'b01; req_a[0] = 10; req_b[0] = 20; req_ctrl[0] = 4'b0000;
    cycle();
    rsp_ready = 2'b10; req_valid = 2'b11;
    req_a[0] = 100; req_b[0] = 1;
    req_a[1] = 2; req_b[1] = 3; req_ctrl[1] = 4'b0000;
    #1 chk("bp_ready_a", 32'(req_ready), 32'h2);
    cycle();
    chk("bp_hold_valid", 32'(rsp_valid[0]), 32'h1);
    chk("bp_hold_result", rsp_result[0], 32'd30);
    chk("bp_p1_result", rsp_result[1], 32'd5);
    req_valid = 2'b01;
    #1 chk("bp_ready_b", 32'(req_ready), 32'h0);
    cycle();
    chk("bp_hold_result2", rsp_result[0], 32'd30);
    rsp_ready = 2'b11;
    #1 chk("bp_refill_ready", 32'(req_ready), 32'h1);
    cycle();
    req_valid = 2'b00;
    chk("bp_refill_valid", 32'(rsp_valid[0]), 32'h1);
    chk("bp_refill_result", rsp_result[0], 32'd101);

    // illegal op, then a legal op clears the flag
    req_valid = 2'b01; req_a[0] = 5; req_b[0] = 5; req_ctrl[0] = 4'b0111;
    cycle();
    chk("ill_flag", 32'(rsp_illegal[0]), 32'h1);
    chk("ill_result", rsp_result[0], 32'h0);
    chk("ill_zero", 32'(rsp_zero[0]), 32'h1);
    req_a[0] = 1; req_b[0] = 1; req_ctrl[0] = 4'b0000;
    cycle();
    req_valid = 2'b00;
    chk("ill_clear", 32'(rsp_illegal[0]), 32'h0);
    chk("ill_next_result", rsp_result[0], 32'd2);

    // reset right after an acceptance discards it and restores priority
    req_valid = 2'b01; req_a[0] = 1; req_b[0] = 2;
    cycle();
    reset = 1; req_valid = 2'b11;
    req_a[0] = 9; req_b[0] = 9; req_a[1] = 4; req_b[1] = 4;
    #1 chk("rst_req_ready", 32'(req_ready), 32'h0);
    cycle();
    reset = 0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    #1 chk("rst_first_grant", 32'(req_ready), 32'h1);
    cycle();
    cycle();
    req_valid = 2'b00;
    cycle();

    // randomized traffic under the requester hold rule
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || m_last_g == i) begin
          if ($urandom_range(0, 3) != 0) begin
            req_valid[i] = 1'b1;
            req_a[i]     = rnd_op();
            req_b[i]     = rnd_op();
            req_ctrl[i]  = 4'($urandom_range(0, 15));
          end else req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      cycle();
    end
    reset = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one instance of the team's 32-bit ALU between two requesters, e.g. the integer execute stage and the branch/address-compare unit.
- Round-robin arbitration with valid/ready request handshakes.
- Each port has its own registered response slot with valid/ready backpressure.
- Sustained throughput is one ALU operation per cycle across both ports; each op has 1-cycle request-to-response latency.

Parameters:
- FIRST_PRIO, default 0: port that holds priority after reset (0 or 1).
- CHECK_OPS, default 1: when 1, unsupported alucontrol codes raise rsp_illegal and force the result to 0. When 0, codes pass through unflagged and the result is unspecified.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port request accepted this cycle
- req_a  in  2x32  operand a, per port
- req_b  in  2x32  operand b, per port
- req_ctrl  in  2x4  ALU op code, per port
- rsp_valid  out  2  per-port response held valid
- rsp_ready  in  2  per-port response consumed
- rsp_result  out  2x32  registered ALU result
- rsp_zero  out  2  registered zero flag (sum == 0)
- rsp_lt  out  2  registered signed less-than flag (sum[31] ^ overflow)
- rsp_illegal  out  2  op code was unsupported

Behaviour:
- Reset (synchronous, active-high): rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_lt=0, rsp_illegal=0, prio=FIRST_PRIO. req_ready is 0 while reset is high. Reset mid-operation discards any accepted-but-unconsumed response; no response appears after reset.
- Op codes:
  - Supported: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 1000 srl, 1110 sra.
  - All others are illegal.
  - Shift amount is b[4:0].
- Eligibility: port i is eligible when req_valid[i]=1 AND (rsp_valid[i]=0 OR rsp_ready[i]=1). The second term allows a same-cycle drain and refill.
- Grant (combinational, at most one port per cycle):
  - Exactly one port eligible: that port is granted.
  - Both ports eligible: port prio is granted.
  - No port eligible: no grant.
- req_ready[i] = grant[i]. req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Requester rule: once req_valid is asserted, it and the operands are held stable until accepted (valid & ready).
- On acceptance of port g:
  - The ALU is driven with req_a[g], req_b[g], req_ctrl[g].
  - On the next edge, rsp_result[g], rsp_zero[g], rsp_lt[g], rsp_illegal[g] are loaded and rsp_valid[g] is set to 1.
  - prio becomes ~g.
- With no grant, the ALU inputs are held at the last values; no register other than the response-clear logic changes.
- Response hold: while rsp_valid[i]=1 and rsp_ready[i]=0, all rsp_*[i] outputs are held stable.
- Response clear: when rsp_ready[i]=1 and port i is not granted in the same cycle, rsp_valid[i] clears on the next edge. The data registers keep their old values.
- Latency: acceptance in cycle N gives rsp_valid in cycle N+1. There is no combinational path from req_* to rsp_*.
- Illegal op with CHECK_OPS=1: rsp_result=0, rsp_zero=1, rsp_lt=0, rsp_illegal=1. The handshake and prio update proceed normally.
- zero and lt are always computed from the adder path (a + (b or ~b) + ctrl[0]), independent of the selected result. For logic and shift ops they are still reported from that path.
- Starvation bound: a continuously valid port is granted within 2 cycles of becoming eligible.

Test Plan:
- Single op, port 0: a=5, b=7, ctrl=0000, rsp_ready=1 -> req_ready[0]=1 in cycle 0; cycle 1: rsp_valid[0]=1, result=12, zero=0, lt=0, illegal=0.
- Sub/slt, port 1:
  - a=3, b=3, ctrl=0001 -> result=0, zero=1.
  - Then a=0xFFFFFFFF, b=1, ctrl=0101 -> result=1, lt=1.
  - Then a=0x7FFFFFFF, b=0xFFFFFFFF, ctrl=0101 (overflow case) -> result=0, lt=0.
- Contention: both ports valid every cycle, rsp_ready=11, FIRST_PRIO=0 -> grants alternate 0,1,0,1 over 4 cycles. Each port sees rsp_valid every other cycle with the correct results (e.g. port0 a=1, b<<: ctrl=0110, b=4 -> 16; port1 ctrl=1110, a=0x80000000, b=31 -> 0xFFFFFFFF).
- Backpressure: port 0 rsp_ready=0 after one accepted add (10+20) -> rsp_valid[0] stays 1 with result=30 held. Port 0 req_ready stays 0 while port 1 is still served. Raising rsp_ready[0] with a new request valid -> same-cycle drain and refill; the next cycle shows the new result.
- Illegal op: ctrl=0111, CHECK_OPS=1 -> rsp_illegal=1, result=0, zero=1. The next legal op on the same port clears illegal.
- Reset mid-operation: accept an op in cycle N, assert reset in cycle N+1 -> rsp_valid=00 and req_ready=00 the cycle after reset. prio returns to FIRST_PRIO, confirmed by the first contended grant after reset going to port 0.
